// File: rtl/ram_pkg.sv
// Shared types and helpers for the synchronous single-port RAM.
// Holds the clear/idle state encoding, latency bounds and address-width helper.
package ram_pkg;

  typedef enum logic {
    CLEAR,
    IDLE
  } state_t;

  localparam int READ_LATENCY_MIN = 1;
  localparam int READ_LATENCY_MAX = 2;

  function automatic int addr_w(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ram_sp_sync_if.sv
// Request/response bundle of the single-port RAM.
// master drives requests and clear_start; slave returns ready, busy and read data.
interface ram_sp_sync_if
  import ram_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) ();

  localparam int ADDR_W = addr_w(DEPTH);
  localparam int BE_W   = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [BE_W-1:0]   req_be;
  logic              clear_start;
  logic              init_busy;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr,
    output req_wdata, req_be, clear_start,
    input  req_ready, init_busy,
    input  rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr,
    input  req_wdata, req_be, clear_start,
    output req_ready, init_busy,
    output rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/ram_core_array.sv
// Plain storage: byte-enable write port, registered read port, no reset.
// Ports: i_we/i_be/i_wdata write, i_re read into o_rdata, shared i_addr.
module ram_core_array #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [BE_W-1:0]   i_be,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (i_be[b]) begin
          r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
    if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ram_sp_sync.sv
// Synchronous single-port RAM with clear engine and 1/2-cycle read latency.
// Ports: clk, rst_n (async low), bus (slave side of ram_sp_sync_if).
module ram_sp_sync
  import ram_pkg::*;
#(
  parameter int              DATA_W       = 8,
  parameter int              DEPTH        = 16,
  parameter int              READ_LATENCY = 1,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input logic          clk,
  input logic          rst_n,
  ram_sp_sync_if.slave bus
);

  localparam int ADDR_W = addr_w(DEPTH);
  localparam int BE_W   = DATA_W / 8;
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  if (DATA_W % 8 != 0) begin : g_bad_dw
    $error("DATA_W must be a multiple of 8");
  end
  if (READ_LATENCY < READ_LATENCY_MIN ||
      READ_LATENCY > READ_LATENCY_MAX) begin : g_bad_lat
    $error("READ_LATENCY must be 1 or 2");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("DEPTH must be at least 2");
  end

  state_t            r_state;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic              r_ready;
  logic              r_busy;
  logic              r_v1;
  logic              r_e1;
  logic              r_ok;

  logic              w_acc;
  logic              w_in_rng;
  logic              w_clr;
  logic              w_we;
  logic              w_re;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic [BE_W-1:0]   w_be;
  logic [DATA_W-1:0] w_rdata;
  logic [DATA_W-1:0] w_d1;

  assign w_acc    = bus.req_valid && r_ready;
  assign w_in_rng = {1'b0, bus.req_addr} < DEPTH_X;
  assign w_clr    = (r_state == CLEAR);

  // Clear engine owns the port while busy; ready is low then.
  assign w_we    = w_clr || (w_acc && bus.req_we && w_in_rng);
  assign w_re    = w_acc && !bus.req_we && w_in_rng;
  assign w_addr  = w_clr ? r_clr_cnt : bus.req_addr;
  assign w_wdata = w_clr ? INIT_VALUE : bus.req_wdata;
  assign w_be    = w_clr ? '1 : bus.req_be;

  ram_core_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .BE_W   (BE_W)
  ) u_core (
    .clk     (clk),
    .i_we    (w_we),
    .i_re    (w_re),
    .i_addr  (w_addr),
    .i_wdata (w_wdata),
    .i_be    (w_be),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= CLEAR;
      r_clr_cnt <= '0;
      r_ready   <= 1'b0;
      r_busy    <= 1'b1;
    end else begin
      unique case (r_state)
        CLEAR: begin
          r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
          if (r_clr_cnt == LAST) begin
            r_state   <= IDLE;
            r_clr_cnt <= '0;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
          end
        end
        IDLE: begin
          if (bus.clear_start) begin
            r_state   <= CLEAR;
            r_clr_cnt <= '0;
            r_ready   <= 1'b0;
            r_busy    <= 1'b1;
          end
        end
      endcase
    end
  end

  // r_ok masks the unreset array register and forces 0 on bad reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1 <= 1'b0;
      r_e1 <= 1'b0;
      r_ok <= 1'b0;
    end else begin
      r_v1 <= w_acc && !bus.req_we;
      r_e1 <= w_acc && !bus.req_we && !w_in_rng;
      if (w_acc && !bus.req_we) begin
        r_ok <= w_in_rng;
      end
    end
  end

  assign w_d1 = r_ok ? w_rdata : '0;

  if (READ_LATENCY == READ_LATENCY_MAX) begin : g_lat2
    logic              r_v2;
    logic              r_e2;
    logic [DATA_W-1:0] r_d2;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v2 <= 1'b0;
        r_e2 <= 1'b0;
        r_d2 <= '0;
      end else begin
        r_v2 <= r_v1;
        r_e2 <= r_e1;
        if (r_v1) begin
          r_d2 <= w_d1;
        end
      end
    end

    assign bus.rsp_valid = r_v2;
    assign bus.rsp_err   = r_e2;
    assign bus.rsp_rdata = r_d2;
  end else begin : g_lat1
    assign bus.rsp_valid = r_v1;
    assign bus.rsp_err   = r_e1;
    assign bus.rsp_rdata = w_d1;
  end

  assign bus.req_ready = r_ready;
  assign bus.init_busy = r_busy;

endmodule
